alu_rot_stage: RTL and testbench
================================

# alu_rot_stage

Pipelined, handshaked execution stage for the 7-bit rotate unit in the ALU datapath. It accepts a rotate command (operand, amount, direction) from the ALU issue logic and maps left rotates onto the right-rotate core. It registers the result and status flags for writeback, sustaining one operation per cycle under backpressure. It sits between the ALU operand/issue stage and the writeback/flag register stage.

## Interface
Parameters:
- `CNT_W`, 8, width of the completed-operation counter.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; synchronous, active-low.
- `in_valid`  input  1  command valid.
- `in_ready`  output  1  stage can accept a command this cycle.
- `in_data`  input  7  operand.
- `in_amt`  input  3  rotate amount, 0..7.
- `in_dir`  input  1  0 = rotate right, 1 = rotate left.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  7  rotated result.
- `out_zero`  output  1  result == 0.
- `out_carry`  output  1  last bit rotated out.
- `op_count`  output  CNT_W  completed operations, saturating.
- `cnt_clr`  input  1  synchronous clear of `op_count`.

## Operation
- Stage S1 registers `{in_data, in_amt, in_dir}` on accept (`in_valid && in_ready`).
- Effective right amount `r`:
  - `in_amt` 0 or 7 gives `r = 0`; pass-through, since the core treats 7 as identity.
  - For right rotates, `r = amt` for amt 1..6.
  - For left rotates, `r = 7 - amt` for amt 1..6. Example: left 1 becomes right 6.
  - `r` is computed in S1 and stored as 3 bits.
- The rotate core computes `out = in` rotated right by `r` between S1 and S2.
- S2 registers the result and flags:
  - `out_zero = (result == 7'd0)`.
  - `out_carry` for `r = 0`: 0.
  - `out_carry` for a right rotate with `r ≠ 0`: equals `in[amt-1]`, which is `result[6]`.
  - `out_carry` for a left rotate with `r ≠ 0`: equals `in[7-amt]`, which is `result[0]`.
- Flow control:
  - S1 advances when `!s2_valid || out_ready`.
  - `in_ready = !s1_valid || s1_advance`. This is a combinational ready chain with no bubbles.
- `out_valid` = S2 valid.
  - While `out_valid && !out_ready`, `out_data`, `out_zero` and `out_carry` hold stable.
- `op_count` increments by 1 on each output handshake (`out_valid && out_ready`).
  - It saturates at all-ones.
  - `cnt_clr` wins over a simultaneous increment; the count becomes 0.

## Timing
- Latency: an accept in cycle N gives `out_valid` in cycle N+2 when there is no backpressure.
- Throughput: 1 op/cycle while `out_ready` is held high.
- Reset (`rst_n` low at a clock edge):
  - S1 and S2 valids become 0, so `out_valid = 0`.
  - `in_ready` becomes 1 in the cycle after reset.
  - `out_data = 0`, `out_zero = 0`, `out_carry = 0`, `op_count = 0`.
  - Reset mid-operation drops in-flight commands silently; nothing is emitted afterwards.
- Full: with S1 and S2 both valid and `out_ready = 0`, `in_ready = 0`. Capacity is 2 commands.
- Simultaneous accept and output handshake in the same cycle with both stages full: both stages shift, the new command enters S1, and no data is lost.
- `in_valid` with `in_ready = 0` is not captured; upstream must hold its command.
- `in_data`, `in_amt` and `in_dir` are ignored when `in_valid = 0`.

## Structure
- Shared ALU package:
  - direction constants `ROT_RIGHT = 1'b0`, `ROT_LEFT = 1'b1`.
  - the 7-bit data width constant.
  - a function mapping `(amt, dir)` to the effective right amount.
- Sub-module: the existing 7-bit rotate-right core, instantiated once between S1 and S2. No other sub-modules.
- Valid/ready logic and the counter live inline.

## Test plan
- Reset, then right rotate: `in_data = 7'b0000001`, amt 1 → two cycles later `out_data = 7'b1000000`, `out_carry = 1`, `out_zero = 0`.
- Left rotate: `in_data = 7'b1000000`, amt 1 → `out_data = 7'b0000001`, `out_carry = 1`.
- Pass-through amounts: amt 0 and amt 7 with data `7'h55`, both directions → `out_data = 7'h55`, `out_carry = 0`. Data 0 → `out_zero = 1`.
- Backpressure: stream 4 commands with `out_ready = 0`.
  - `in_ready` falls after 2 accepts.
  - Raise `out_ready` → results appear in order at 1/cycle with stable outputs while stalled.
  - `op_count = 4`.
- Counter: 300 back-to-back ops with `CNT_W = 8` → `op_count = 255`. Pulse `cnt_clr` during a handshake → `op_count = 0`.
- Reset mid-stream with 2 commands in flight → `out_valid = 0` and `op_count = 0` the next cycle, and no stale results appear after reset release.

Source files
------------

// File: rtl/alu_rot_stage_pkg.sv
// Shared ALU rotate definitions: data width, direction encodings, stage payloads
// and the left-to-right amount mapping used by the rotate stage.
package alu_rot_stage_pkg;

    localparam int DATA_W = 7;

    localparam logic ROT_RIGHT = 1'b0;
    localparam logic ROT_LEFT  = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        r;
        logic              dir;
    } s1_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              carry;
    } s2_res_t;

    // Left rotates reuse the right-rotate core: left by k == right by 7-k.
    function automatic logic [2:0] eff_right_amt(input logic [2:0] amt, input logic dir);
        if (amt == 3'd0 || amt == 3'd7) begin
            return 3'd0;
        end
        if (dir == ROT_LEFT) begin
            return 3'd7 - amt;
        end
        return amt;
    endfunction

endpackage

// File: rtl/alu_rot_stage_ror.sv
// Combinational 7-bit rotate-right core; an amount of 7 is the identity.
module alu_rot_stage_ror
    import alu_rot_stage_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [2:0]        amt,
    output logic [DATA_W-1:0] dout
);

    logic [2*DATA_W-1:0] dbl;

    // Shifting the doubled word wraps the low bits back in from the top copy.
    always_comb begin
        dbl  = {din, din} >> amt;
        dout = dbl[DATA_W-1:0];
    end

endmodule

// File: rtl/alu_rot_stage.sv
// Two-stage handshaked rotate execution stage: S1 holds the command, S2 holds the
// rotated result and flags for writeback, plus a saturating completion counter.
module alu_rot_stage
    import alu_rot_stage_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_amt,
    input  logic              in_dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_carry,
    output logic [CNT_W-1:0]  op_count,
    input  logic              cnt_clr
);

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    s1_cmd_t           s1_cmd_q, s1_cmd_d;
    s2_res_t           s2_res_q, s2_res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1_advance;
    logic              accept;
    logic              out_fire;
    logic [DATA_W-1:0] rot_data;

    alu_rot_stage_ror u_ror (
        .din  (s1_cmd_q.data),
        .amt  (s1_cmd_q.r),
        .dout (rot_data)
    );

    // Valid/ready contract: a transfer happens on a port exactly when valid && ready
    // are both high at a rising edge; S1 may refill in the same cycle it drains.
    always_comb begin
        s1_advance = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s1_advance;
        accept     = in_valid && in_ready;
        out_fire   = s2_valid_q && out_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cmd_d   = s1_cmd_q;
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_cmd_d.data = in_data;
            s1_cmd_d.r    = eff_right_amt(in_amt, in_dir);
            s1_cmd_d.dir  = in_dir;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // The carry is the last bit to leave: the MSB after a right rotate, the LSB after a left one.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d.data  = rot_data;
                s2_res_d.zero  = (rot_data == '0);
                s2_res_d.carry = 1'b0;
                if (s1_cmd_q.r != 3'd0) begin
                    s2_res_d.carry = (s1_cmd_q.dir == ROT_LEFT) ? rot_data[0]
                                                                : rot_data[DATA_W-1];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_cmd_q   <= '0;
            s2_res_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_cmd_q   <= s1_cmd_d;
            s2_res_q   <= s2_res_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        out_valid = s2_valid_q;
        out_data  = s2_res_q.data;
        out_zero  = s2_res_q.zero;
        out_carry = s2_res_q.carry;
        op_count  = cnt_q;
    end

endmodule

// File: tb/tb_alu_rot_stage.sv
// Bench for alu_rot_stage: directed cases from the rotate rules plus randomized
// traffic checked against a queue-based reference model.
module tb_alu_rot_stage;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_data = '0;
    logic [2:0]       in_amt = '0;
    logic             in_dir = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [6:0]       out_data;
    logic             out_zero;
    logic             out_carry;
    logic [CNT_W-1:0] op_count;
    logic             cnt_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    int         exp_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_word = '0;

    alu_rot_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .op_count  (op_count),
        .cnt_clr   (cnt_clr)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: rotation by arithmetic on the operand, {result, zero, carry}.
    function automatic logic [8:0] ref_rot(input logic [6:0] d, input logic [2:0] amt, input logic dir);
        int v = int'(d);
        int k = (amt == 3'd0 || amt == 3'd7) ? 0 : int'(amt);
        int res;
        int car;
        if (k == 0) begin
            res = v;
            car = 0;
        end else if (dir == 1'b0) begin
            res = ((v >> k) | (v << (7 - k))) & 127;
            car = (v >> (k - 1)) & 1;
        end else begin
            res = ((v << k) | (v >> (7 - k))) & 127;
            car = (v >> (7 - k)) & 1;
        end
        return {res[6:0], (res == 0), car[0]};
    endfunction

    // scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            check_eq("op_count", int'(op_count), exp_cnt);
            if (stall_prev) begin
                check_eq("stall_valid", int'(out_valid), 1);
                check_eq("stall_hold", int'({out_data, out_zero, out_carry}), int'(stall_word));
            end
            if (out_valid) begin
                check_eq("no_spurious_out", int'(exp_q.size() > 0), 1);
                if (out_ready && exp_q.size() > 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check_eq("result", int'({out_data, out_zero, out_carry}), int'(e));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_rot(in_data, in_amt, in_dir));
            if (cnt_clr) exp_cnt = 0;
            else if (out_valid && out_ready && exp_cnt != CNT_MAX) exp_cnt++;
            stall_prev = out_valid && !out_ready;
            stall_word = {out_data, out_zero, out_carry};
        end
    end

    // driver tasks
    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_cmd(input logic [6:0] d, input logic [2:0] a, input logic dir);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check_eq("push_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) check_eq("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // One command with no backpressure: empty at N+1, result at N+2.
    task automatic single_op(input string tag, input logic [6:0] d, input logic [2:0] a,
                             input logic dir, input logic [6:0] ed, input logic ez, input logic ec);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_dir    = dir;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat1"}, int'(out_valid), 0);
        @(negedge clk);
        check_eq({tag, "_lat2"}, int'(out_valid), 1);
        check_eq({tag, "_data"}, int'(out_data), int'(ed));
        check_eq({tag, "_zero"}, int'(out_zero), int'(ez));
        check_eq({tag, "_carry"}, int'(out_carry), int'(ec));
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        do_reset(2);
        @(negedge clk);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_out_word", int'({out_data, out_zero, out_carry}), 0);
        check_eq("rst_op_count", int'(op_count), 0);
        @(posedge clk); #1;

        single_op("ror1", 7'b0000001, 3'd1, 1'b0, 7'b1000000, 1'b0, 1'b1);
        single_op("rol1", 7'b1000000, 3'd1, 1'b1, 7'b0000001, 1'b0, 1'b1);
        single_op("ror0", 7'h55, 3'd0, 1'b0, 7'h55, 1'b0, 1'b0);
        single_op("rol0", 7'h55, 3'd0, 1'b1, 7'h55, 1'b0, 1'b0);
        single_op("ror7", 7'h55, 3'd7, 1'b0, 7'h55, 1'b0, 1'b0);
        single_op("rol7", 7'h55, 3'd7, 1'b1, 7'h55, 1'b0, 1'b0);
        single_op("zero", 7'h00, 3'd3, 1'b1, 7'h00, 1'b1, 1'b0);
        single_op("rol3", 7'b0010110, 3'd3, 1'b1, 7'b0110001, 1'b0, 1'b1);

        // Backpressure: capacity 2, then release in order.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        push_cmd(7'h11, 3'd2, 1'b0);
        push_cmd(7'h22, 3'd4, 1'b1);
        @(negedge clk);
        check_eq("full_in_ready", int'(in_ready), 0);
        fork
            begin
                push_cmd(7'h33, 3'd5, 1'b0);
                push_cmd(7'h44, 3'd6, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_op_count", int'(op_count), 4);

        // Saturation: 300 back-to-back ops.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data  = 7'($urandom_range(0, 127));
            in_amt   = 3'($urandom_range(0, 7));
            in_dir   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        check_eq("sat_op_count", int'(op_count), CNT_MAX);

        // Clear during a live output handshake.
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("clr_hs_active", int'(out_valid && out_ready), 1);
        @(posedge clk); #1;
        cnt_clr  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_op_count", int'(op_count), 0);
        drain();

        // Reset with two commands in flight.
        out_ready = 1'b0;
        push_cmd(7'h5a, 3'd1, 1'b0);
        push_cmd(7'h3c, 3'd2, 1'b1);
        do_reset(1);
        @(negedge clk);
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_op_count", int'(op_count), 0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 7'($urandom_range(0, 127));
            in_amt    = 3'($urandom_range(0, 7));
            in_dir    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        base = n_checks;
        drain();
        check_eq("final_queue_empty", exp_q.size(), 0);
        check_eq("random_checked", int'(n_checks > base), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
